alu_share_ctrl: RTL

- Multi-requester controller that shares one 32-bit MIPS ALU datapath between NUM_REQ clients.
- Round-robin arbitration over a valid/ready request interface; the winning request's operands and control are latched, executed on the ALU, and held in a result register until consumed.
- Sits between issue logic (e.g. address unit, branch unit, execute stage) and the single shared ALU.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/MIPS_ALU.sv | 28 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/alu_share_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller: ALU control codes,
// controller FSM encoding and the operand width of the MIPS datapath.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/MIPS_ALU.sv
// Combinational 32-bit MIPS ALU. SLT is an unsigned compare; unknown
// control codes produce zero.
module MIPS_ALU
  import alu_pkg::*;
(
  input  logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr, wrapping around, and reports both one-hot and index forms.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any
);

  logic [ID_W-1:0] sel;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sel     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[sel]) begin
        any      = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one MIPS ALU between NUM_REQ requesters: round-robin accept, one
// execute cycle, then a held response. Define ALU_OVF_EN to add rsp_ovf.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  input  logic [NUM_REQ*4-1:0]   req_ctrl,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_result,
  output logic                   rsp_zero
`ifdef ALU_OVF_EN
  ,
  output logic                   rsp_ovf
`endif
);

`ifdef ALU_OVF_EN
  function automatic logic ovf_detect(input logic [CTRL_W-1:0] ctrl,
                                      input logic signed [DATA_W-1:0] a,
                                      input logic signed [DATA_W-1:0] b,
                                      input logic signed [DATA_W-1:0] r);
    logic ovf;
    ovf = 1'b0;
    if (ctrl == ALU_ADD)
      ovf = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    else if (ctrl == ALU_SUB)
      ovf = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    return ovf;
  endfunction
`endif

  state_t state, state_nxt;

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic               accept;

  logic [DATA_W-1:0]  a_arr    [NUM_REQ];
  logic [DATA_W-1:0]  b_arr    [NUM_REQ];
  logic [CTRL_W-1:0]  ctrl_arr [NUM_REQ];

  logic [DATA_W-1:0]  a_p0;
  logic [DATA_W-1:0]  b_p0;
  logic [CTRL_W-1:0]  ctrl_p0;
  logic [ID_W-1:0]    id_p0;

  logic [DATA_W-1:0]  alu_result;
  logic               alu_zero;
  logic [DATA_W-1:0]  result_p1;
  logic               zero_p1;
`ifdef ALU_OVF_EN
  logic               ovf_p1;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i]    = req_a[i*32 +: 32];
    assign b_arr[i]    = req_b[i*32 +: 32];
    assign ctrl_arr[i] = req_ctrl[i*4 +: 4];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Control: accept only in IDLE; reset also masks the combinational strobe
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (gnt_any && !reset) begin
          req_ready = gnt;
          accept    = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      id_p0  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr_ptr <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
        id_p0  <= gnt_idx;
      end
    end
  end

  // Stage p0: operands captured at accept
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0    <= a_arr[gnt_idx];
      b_p0    <= b_arr[gnt_idx];
      ctrl_p0 <= ctrl_arr[gnt_idx];
    end
  end

  MIPS_ALU u_alu (
    .alu_ctrl (ctrl_p0),
    .a        (a_p0),
    .b        (b_p0),
    .result   (alu_result),
    .zero     (alu_zero)
  );

  // Stage p1: result register, written in EXEC and held through RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_p1 <= '0;
      zero_p1   <= 1'b0;
`ifdef ALU_OVF_EN
      ovf_p1    <= 1'b0;
`endif
    end else if (state == S_EXEC) begin
      result_p1 <= alu_result;
      zero_p1   <= alu_zero;
`ifdef ALU_OVF_EN
      ovf_p1    <= ovf_detect(ctrl_p0, a_p0, b_p0, alu_result);
`endif
    end
  end

  assign rsp_valid  = (state == S_RESP);
  assign rsp_id     = id_p0;
  assign rsp_result = result_p1;
  assign rsp_zero   = zero_p1;
`ifdef ALU_OVF_EN
  assign rsp_ovf    = ovf_p1;
`endif

endmodule
